inst_queue: RTL
===============

# inst_queue

Instruction queue between instruction memory and decode. Buffers up to DEPTH fetched {pc, instruction} pairs so fetch can run ahead of a stalled decode. Splits the head instruction into opcode, imm16 and jmp_imm26 fields for decode and for the fetch unit's branch/jump adders. Discards all buffered entries in one cycle when fetch redirects on a taken branch or jump.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- W, 32, instruction and PC width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; clears the queue.
- flush  input  1  discard all entries; asserted by fetch on redirect (branch | jmp taken).
- in_valid  input  1  fetch presents a pair this cycle.
- in_pc  input  W  PC of fetched instruction.
- in_inst  input  W  fetched instruction word.
- in_ready  output  1  queue accepts a pair this cycle.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes head this cycle.
- out_pc  output  W  head PC.
- out_inst  output  W  head instruction.
- out_opcode  output  6  out_inst[31:26].
- out_imm16  output  16  out_inst[15:0].
- out_jmp_imm26  output  26  out_inst[25:0].
- count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.

## Operation
- Circular buffer: write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits each), and an occupancy counter.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). There is no pass-through at full: a pop in a full cycle does not enable a push in the same cycle.
- out_valid = (count != 0).
- Push: entry[wr_ptr] <= {in_pc, in_inst}; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap from DEPTH-1 to 0 with no gap.
- When count == 0, out_pc, out_inst and all field outputs drive 0, not stale storage.
- Field outputs are pure slices of the masked out_inst.
- flush has priority over push and pop:
  - wr_ptr, rd_ptr and count go to 0 at the next edge.
  - A push or pop in the flush cycle has no effect.
  - in_ready and out_valid still follow count during the flush cycle.
- Storage contents are not cleared by reset or flush. Only the pointers and count are cleared; output masking hides the stale data.

## Timing
- Reset (reset low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0. Outputs: in_ready = 1, out_valid = 0, out_* = 0.
- Deassertion of reset is synchronised externally; no push is taken in the cycle reset rises.
- Latency: an entry pushed at edge N is visible on out_* after edge N. Earliest pop is the cycle after the push. There is no empty bypass.
- Head outputs come combinationally from registered pointers and storage; they never depend combinationally on out_ready.
- in_ready and out_valid depend only on registered count, so there is no combinational path from in_valid or out_ready to them.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH.
- Reset asserted mid-operation clears state immediately, regardless of the clock.

## Structure
- Shared package inst_queue_pkg holds:
  - Field positions as constants: OPC_HI = 31, OPC_LO = 26, IMM16_HI = 15, JMP_HI = 25.
  - NOP_INST = 32'h0000_0000.
  - An entry struct {pc, inst}.
- One sub-module, ptr_counter: a log2(DEPTH)-bit wrap-around counter with increment enable, synchronous clear (flush) and asynchronous active-low reset.
  - Instantiated twice, once for wr_ptr and once for rd_ptr.
- Storage is a register array in the top module; the occupancy counter is inline.

## Test plan
- Reset and fill:
  - Stimulus: reset low, then push 0x00400000/0x8C010004 through four sequential pairs, out_ready = 0.
  - Response: count steps 1..4; in_ready = 0 at count 4. A fifth in_valid is ignored and count stays 4.
- Drain with field split:
  - Stimulus: from full, hold out_ready = 1.
  - Response: the four heads appear in push order, one per cycle. For inst 0x1043FFFD: out_opcode = 6'h04, out_imm16 = 16'hFFFD, out_jmp_imm26 = 26'h043FFFD. Then out_valid = 0 and out_inst = 0.
- Wrap-around:
  - Stimulus: 10 cycles of simultaneous push and pop at count 2.
  - Response: count stays 2, output order is preserved across pointer wrap, no entry is lost or duplicated.
- Flush with simultaneous push and pop:
  - Stimulus: count 3, flush = 1 together with in_valid = 1 and out_ready = 1.
  - Response: next cycle count = 0, out_valid = 0, and the pushed pair never appears.
- Full-cycle pop:
  - Stimulus: count 4, out_ready = 1 and in_valid = 1.
  - Response: push is rejected, next cycle count = 3.
- Async reset mid-stream:
  - Stimulus: pull reset low between edges while count = 2.
  - Response: count = 0 and out_valid = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue: instruction field positions,
// the NOP encoding and the {pc, inst} entry layout.
package inst_queue_pkg;

  localparam int XLEN     = 32;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int IMM16_HI = 15;
  localparam int IMM16_LO = 0;
  localparam int JMP_HI   = 25;
  localparam int JMP_LO   = 0;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  // An empty queue must present zeros rather than whatever is left in storage.
  function automatic logic [XLEN-1:0] mask_head(input logic vld, input logic [XLEN-1:0] val);
    logic [XLEN-1:0] res;
    if (vld) begin
      res = val;
    end else begin
      res = NOP_INST;
    end
    return res;
  endfunction

endpackage

// File: rtl/inst_queue_ptr_counter.sv
// Wrap-around pointer for the instruction queue. The width is log2(DEPTH)
// bits, so the natural overflow of the counter gives the modulo-DEPTH wrap.
module ptr_counter #(
  parameter int PW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: a clear overrides any increment in the same cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = ptr_q + PW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between instruction memory and decode: buffers fetched
// {pc, inst} pairs, splits the head into decode fields and flushes on redirect.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_pc,
  input  logic [W-1:0]           in_inst,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_pc,
  output logic [W-1:0]           out_inst,
  output logic [5:0]             out_opcode,
  output logic [15:0]            out_imm16,
  output logic [25:0]            out_jmp_imm26,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push;
  logic          pop;
  entry_t        mem_q [DEPTH];
  entry_t        head;

  // Ready/valid look only at the registered count, so no input reaches them combinationally.
  assign in_ready  = (count_q != FULL_C);
  assign out_valid = (count_q != CW'(0));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  ptr_counter #(.PW(PW)) u_wr_ptr (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (flush),
    .en_i   (push),
    .ptr_o  (wr_ptr)
  );

  ptr_counter #(.PW(PW)) u_rd_ptr (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (flush),
    .en_i   (pop),
    .ptr_o  (rd_ptr)
  );

  // Occupancy next state: flush wins, a simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset and flush; output masking hides stale data.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end
  end

  // Head outputs come from registered pointer and storage only.
  always_comb begin
    head      = mem_q[rd_ptr];
    head.pc   = mask_head(out_valid, head.pc);
    head.inst = mask_head(out_valid, head.inst);
  end

  assign out_pc        = head.pc;
  assign out_inst      = head.inst;
  assign out_opcode    = out_inst[OPC_HI:OPC_LO];
  assign out_imm16     = out_inst[IMM16_HI:IMM16_LO];
  assign out_jmp_imm26 = out_inst[JMP_HI:JMP_LO];
  assign count         = count_q;

endmodule
